// File: rtl/ss_sg_arb.sv
// ss_sg_arb: round-robin Wishbone arbiter between the scatter-gather read
// engine (port 0) and write engine (port 1) sharing one upstream master port.
// Grants move only on cycle boundaries. A watchdog revokes a requester that
// stalls too long, flags it with a one-cycle error and a sticky timeout bit,
// and locks it out until it drops its cycle.
module ss_sg_arb #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        s0_cyc,
  input  logic        s0_stb,
  input  logic        s0_we,
  input  logic        s0_pref,
  input  logic        s0_cab,
  input  logic [3:0]  s0_sel,
  input  logic [31:0] s0_adr,
  output logic        s0_ack,
  output logic        s0_err,
  output logic        s0_rty,
  output logic [31:0] s0_dat_o,
  output logic [31:0] s0_dat64_o,

  input  logic        s1_cyc,
  input  logic        s1_stb,
  input  logic        s1_we,
  input  logic        s1_pref,
  input  logic        s1_cab,
  input  logic [3:0]  s1_sel,
  input  logic [31:0] s1_adr,
  output logic        s1_ack,
  output logic        s1_err,
  output logic        s1_rty,
  output logic [31:0] s1_dat_o,
  output logic [31:0] s1_dat64_o,

  output logic        wbm_cyc,
  output logic        wbm_stb,
  output logic        wbm_we,
  output logic        wbm_pref,
  output logic        wbm_cab,
  output logic [3:0]  wbm_sel,
  output logic [31:0] wbm_adr,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  input  logic        wbm_rty,
  input  logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat64_o,

  output logic [1:0]  arb_gnt,
  output logic [1:0]  arb_to,
  input  logic        arb_to_clr
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t      state;
  state_t      state_nxt;
  logic        last;
  logic [1:0]  lk;
  logic [7:0]  wd_cnt;
  logic        gnt0;
  logic        gnt1;
  logic        rsp;
  logic        to_hit;
  logic [1:0]  to_pulse;
  logic [1:0]  req;
  logic        own_cyc;

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign arb_gnt = state;
  assign rsp     = wbm_ack | wbm_err | wbm_rty;

  // A stall that reaches the limit with no response this cycle revokes the owner.
  assign to_hit   = (state != IDLE) && (wd_cnt == TO_LIM) && !rsp;
  assign to_pulse = {gnt1 & to_hit, gnt0 & to_hit};

  // A timing-out owner is already ineligible in the cycle it is revoked.
  assign req     = {s1_cyc & ~lk[1] & ~to_pulse[1], s0_cyc & ~lk[0] & ~to_pulse[0]};
  assign own_cyc = (gnt0 & s0_cyc) | (gnt1 & s1_cyc);

  // Responses go only to the granted engine; data is broadcast.
  assign s0_ack     = wbm_ack & gnt0;
  assign s1_ack     = wbm_ack & gnt1;
  assign s0_rty     = wbm_rty & gnt0;
  assign s1_rty     = wbm_rty & gnt1;
  assign s0_err     = (wbm_err & gnt0) | to_pulse[0];
  assign s1_err     = (wbm_err & gnt1) | to_pulse[1];
  assign s0_dat_o   = wbm_dat_o;
  assign s1_dat_o   = wbm_dat_o;
  assign s0_dat64_o = wbm_dat64_o;
  assign s1_dat64_o = wbm_dat64_o;

  // Next grant: re-arbitrate only on a cycle boundary or a watchdog revoke.
  always_comb begin
    state_nxt = state;
    if ((state == IDLE) || !own_cyc || to_hit) begin
      unique case (req)
        2'b11:   state_nxt = last ? GNT0 : GNT1;
        2'b01:   state_nxt = GNT0;
        2'b10:   state_nxt = GNT1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Upstream forwarding mux; idle keeps the bus quiet but still shows port 0 qualifiers.
  always_comb begin
    wbm_cyc  = 1'b0;
    wbm_stb  = 1'b0;
    wbm_we   = 1'b0;
    wbm_pref = 1'b0;
    wbm_cab  = s0_cab;
    wbm_sel  = s0_sel;
    wbm_adr  = s0_adr;
    unique case (state)
      GNT0: begin
        wbm_cyc  = s0_cyc;
        wbm_stb  = s0_stb;
        wbm_we   = s0_we;
        wbm_pref = s0_pref;
      end
      GNT1: begin
        wbm_cyc  = s1_cyc;
        wbm_stb  = s1_stb;
        wbm_we   = s1_we;
        wbm_pref = s1_pref;
        wbm_cab  = s1_cab;
        wbm_sel  = s1_sel;
        wbm_adr  = s1_adr;
      end
      default: ;
    endcase
  end

  // Grant state and round-robin history.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0)
        last <= 1'b0;
      else if (state_nxt == GNT1)
        last <= 1'b1;
    end
  end

  // Lockout bits: set on revoke, released once the engine drops its cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lk <= 2'b00;
    end else begin
      lk[0] <= to_pulse[0] | (lk[0] & s0_cyc);
      lk[1] <= to_pulse[1] | (lk[1] & s1_cyc);
    end
  end

  // Watchdog: counts consecutive unanswered strobe cycles of the current grant.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt <= 8'd0;
    end else if ((state_nxt != state) || rsp || !wbm_stb) begin
      wd_cnt <= 8'd0;
    end else if ((state != IDLE) && (wd_cnt != 8'hFF)) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Sticky timeout flags; a same-cycle timeout overrides the clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      arb_to <= 2'b00;
    else
      arb_to <= (arb_to & ~{2{arb_to_clr}}) | to_pulse;
  end

endmodule

// File: tb/tb_ss_sg_arb.sv
// Testbench for ss_sg_arb: directed vector table, hand-written watchdog and
// reset sequences, and randomized traffic checked against a behavioural model.
module tb_ss_sg_arb;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        s0_cyc, s0_stb, s0_we, s0_pref, s0_cab;
  logic [3:0]  s0_sel;
  logic [31:0] s0_adr;
  logic        s0_ack, s0_err, s0_rty;
  logic [31:0] s0_dat_o, s0_dat64_o;
  logic        s1_cyc, s1_stb, s1_we, s1_pref, s1_cab;
  logic [3:0]  s1_sel;
  logic [31:0] s1_adr;
  logic        s1_ack, s1_err, s1_rty;
  logic [31:0] s1_dat_o, s1_dat64_o;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_pref, wbm_cab;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr;
  logic        wbm_ack, wbm_err, wbm_rty;
  logic [31:0] wbm_dat_o, wbm_dat64_o;
  logic [1:0]  arb_gnt, arb_to;
  logic        arb_to_clr;

  ss_sg_arb #(.TO_CYC(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_pref(s0_pref), .s0_cab(s0_cab),
    .s0_sel(s0_sel), .s0_adr(s0_adr), .s0_ack(s0_ack), .s0_err(s0_err), .s0_rty(s0_rty),
    .s0_dat_o(s0_dat_o), .s0_dat64_o(s0_dat64_o),
    .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_pref(s1_pref), .s1_cab(s1_cab),
    .s1_sel(s1_sel), .s1_adr(s1_adr), .s1_ack(s1_ack), .s1_err(s1_err), .s1_rty(s1_rty),
    .s1_dat_o(s1_dat_o), .s1_dat64_o(s1_dat64_o),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_pref(wbm_pref),
    .wbm_cab(wbm_cab), .wbm_sel(wbm_sel), .wbm_adr(wbm_adr),
    .wbm_ack(wbm_ack), .wbm_err(wbm_err), .wbm_rty(wbm_rty),
    .wbm_dat_o(wbm_dat_o), .wbm_dat64_o(wbm_dat64_o),
    .arb_gnt(arb_gnt), .arb_to(arb_to), .arb_to_clr(arb_to_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: -1 nobody, 0/1 the engine holding the bus
  int       m_own;
  int       m_last;
  bit       m_lk [2];
  int       m_stall;   // consecutive unanswered strobe cycles in this grant
  bit [1:0] m_to;

  task automatic model_reset();
    m_own = -1; m_last = 1; m_lk[0] = 0; m_lk[1] = 0; m_stall = 0; m_to = 2'b00;
  endtask

  function automatic bit m_tmo();
    return (m_own >= 0) && (m_stall == TO) && !(wbm_ack || wbm_err || wbm_rty);
  endfunction

  task automatic model_edge();
    bit tmo, rsp, el0, el1, oc, os;
    int nw;
    tmo = m_tmo();
    rsp = wbm_ack || wbm_err || wbm_rty;
    oc  = (m_own == 0) ? s0_cyc : (m_own == 1) ? s1_cyc : 1'b0;
    os  = (m_own == 0) ? s0_stb : (m_own == 1) ? s1_stb : 1'b0;
    el0 = s0_cyc && !m_lk[0] && !(tmo && m_own == 0);
    el1 = s1_cyc && !m_lk[1] && !(tmo && m_own == 1);
    nw  = m_own;
    if (m_own < 0 || !oc || tmo) begin
      if (el0 && el1)  nw = (m_last == 0) ? 1 : 0;
      else if (el0)    nw = 0;
      else if (el1)    nw = 1;
      else             nw = -1;
    end
    if (nw != m_own || rsp || !os) m_stall = 0;
    else if (m_stall < 255)        m_stall++;
    for (int n = 0; n < 2; n++) begin
      if (tmo && m_own == n) begin
        m_lk[n] = 1; m_to[n] = 1;
      end else begin
        if (!((n == 0) ? s0_cyc : s1_cyc)) m_lk[n] = 0;
        if (arb_to_clr) m_to[n] = 0;
      end
    end
    if (nw >= 0) m_last = nw;
    m_own = nw;
  endtask

  task automatic check_all(input string nm);
    bit tmo;
    logic [1:0]  eg;
    logic [31:0] eadr;
    tmo  = m_tmo();
    eg   = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    eadr = (m_own == 1) ? s1_adr : s0_adr;
    chk({nm, ".gnt"},    32'(arb_gnt), 32'(eg));
    chk({nm, ".cyc"},    32'(wbm_cyc), 32'((m_own == 0) ? s0_cyc : (m_own == 1) ? s1_cyc : 1'b0));
    chk({nm, ".stb"},    32'(wbm_stb), 32'((m_own == 0) ? s0_stb : (m_own == 1) ? s1_stb : 1'b0));
    chk({nm, ".we"},     32'(wbm_we),  32'((m_own == 0) ? s0_we : (m_own == 1) ? s1_we : 1'b0));
    chk({nm, ".adr"},    wbm_adr, eadr);
    chk({nm, ".sel"},    32'(wbm_sel), 32'((m_own == 1) ? s1_sel : s0_sel));
    chk({nm, ".s0_ack"}, 32'(s0_ack), 32'(wbm_ack && m_own == 0));
    chk({nm, ".s1_ack"}, 32'(s1_ack), 32'(wbm_ack && m_own == 1));
    chk({nm, ".s0_rty"}, 32'(s0_rty), 32'(wbm_rty && m_own == 0));
    chk({nm, ".s1_rty"}, 32'(s1_rty), 32'(wbm_rty && m_own == 1));
    chk({nm, ".s0_err"}, 32'(s0_err), 32'((wbm_err || tmo) && m_own == 0));
    chk({nm, ".s1_err"}, 32'(s1_err), 32'((wbm_err || tmo) && m_own == 1));
    chk({nm, ".to"},     32'(arb_to), 32'(m_to));
    chk({nm, ".dat"},    s1_dat_o ^ s0_dat64_o, wbm_dat_o ^ wbm_dat64_o);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string nm);
    #2;
    check_all(nm);
    adv();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit c0, t0, c1, t1, ack, err, rty;
    bit [1:0] gnt;
    bit a0, a1, e0, e1, r0, r1;
  } vec_t;

  function automatic vec_t mk(bit c0, bit t0, bit c1, bit t1, bit ack, bit err, bit rty,
                              bit [1:0] gnt, bit a0, bit a1, bit e0, bit e1, bit r0, bit r1);
    vec_t v;
    v.c0 = c0; v.t0 = t0; v.c1 = c1; v.t1 = t1; v.ack = ack; v.err = err; v.rty = rty;
    v.gnt = gnt; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1,1,1,1, 0,0,0, 2'b00, 0,0,0,0,0,0);
    tbl[1]  = mk(1,1,1,1, 1,0,0, 2'b01, 1,0,0,0,0,0);
    tbl[2]  = mk(0,0,1,1, 0,0,0, 2'b01, 0,0,0,0,0,0);
    tbl[3]  = mk(1,1,1,1, 1,0,0, 2'b10, 0,1,0,0,0,0);
    tbl[4]  = mk(1,1,1,1, 0,0,0, 2'b10, 0,0,0,0,0,0);
    tbl[5]  = mk(1,1,0,0, 0,0,0, 2'b10, 0,0,0,0,0,0);
    tbl[6]  = mk(1,1,1,1, 0,1,0, 2'b01, 0,0,1,0,0,0);
    tbl[7]  = mk(1,1,1,1, 0,0,1, 2'b01, 0,0,0,0,1,0);
    tbl[8]  = mk(0,0,1,1, 0,0,0, 2'b01, 0,0,0,0,0,0);
    tbl[9]  = mk(0,0,1,1, 0,1,0, 2'b10, 0,0,0,1,0,0);
    tbl[10] = mk(0,0,1,1, 0,0,1, 2'b10, 0,0,0,0,0,1);
    tbl[11] = mk(0,0,0,0, 1,0,0, 2'b10, 0,1,0,0,0,0);
    tbl[12] = mk(0,0,0,0, 1,0,0, 2'b00, 0,0,0,0,0,0);

    s0_cyc = 0; s0_stb = 0; s0_we = 0; s0_pref = 0; s0_cab = 0; s0_sel = 4'h3; s0_adr = 32'h1000_0000;
    s1_cyc = 0; s1_stb = 0; s1_we = 1; s1_pref = 0; s1_cab = 0; s1_sel = 4'hC; s1_adr = 32'h2000_0000;
    wbm_ack = 1; wbm_err = 1; wbm_rty = 1;
    wbm_dat_o = 32'hDEAD_BEEF; wbm_dat64_o = 32'h0123_4567;
    arb_to_clr = 0;
    rst = 1;
    model_reset();

    // Reset state, with responses driven high to prove they are dropped
    @(posedge clk); #1;
    chk("rst.gnt",    32'(arb_gnt), 32'd0);
    chk("rst.cyc",    32'(wbm_cyc), 32'd0);
    chk("rst.stb",    32'(wbm_stb), 32'd0);
    chk("rst.to",     32'(arb_to),  32'd0);
    chk("rst.s0_ack", 32'(s0_ack),  32'd0);
    chk("rst.s1_ack", 32'(s1_ack),  32'd0);
    chk("rst.s0_err", 32'(s0_err),  32'd0);
    chk("rst.s1_rty", 32'(s1_rty),  32'd0);
    @(posedge clk); #1;
    rst = 0; wbm_ack = 0; wbm_err = 0; wbm_rty = 0;
    model_reset();

    // Contention, handover, routing, idle-ack drop
    for (int i = 0; i < 13; i++) begin
      s0_cyc = tbl[i].c0; s0_stb = tbl[i].t0; s1_cyc = tbl[i].c1; s1_stb = tbl[i].t1;
      wbm_ack = tbl[i].ack; wbm_err = tbl[i].err; wbm_rty = tbl[i].rty;
      #2;
      chk($sformatf("tbl%0d.gnt", i),    32'(arb_gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d.s0_ack", i), 32'(s0_ack),  32'(tbl[i].a0));
      chk($sformatf("tbl%0d.s1_ack", i), 32'(s1_ack),  32'(tbl[i].a1));
      chk($sformatf("tbl%0d.s0_err", i), 32'(s0_err),  32'(tbl[i].e0));
      chk($sformatf("tbl%0d.s1_err", i), 32'(s1_err),  32'(tbl[i].e1));
      chk($sformatf("tbl%0d.s0_rty", i), 32'(s0_rty),  32'(tbl[i].r0));
      chk($sformatf("tbl%0d.s1_rty", i), 32'(s1_rty),  32'(tbl[i].r1));
      check_all($sformatf("tbl%0d", i));
      adv();
    end
    wbm_ack = 0; wbm_err = 0; wbm_rty = 0;

    // Watchdog: s0 stalls, is revoked in its 9th stalled cycle, s1 takes over
    s0_cyc = 1; s0_stb = 1; s1_cyc = 0; s1_stb = 0;
    step("wd_req");
    s1_cyc = 1; s1_stb = 1;
    for (int i = 1; i <= 9; i++) begin
      #2;
      chk($sformatf("wd_stall%0d.s0_err", i), 32'(s0_err), 32'(i == 9));
      chk($sformatf("wd_stall%0d.gnt", i),    32'(arb_gnt), 32'd1);
      check_all("wd_stall");
      adv();
    end
    #2;
    chk("wd_moved.gnt", 32'(arb_gnt), 32'd2);
    chk("wd_moved.to",  32'(arb_to),  32'd1);
    check_all("wd_moved");
    adv();
    s1_cyc = 0; s1_stb = 0;
    step("wd_s1_done");
    #2;
    chk("wd_locked.gnt", 32'(arb_gnt), 32'd0);
    check_all("wd_locked");
    adv();
    s0_cyc = 0; s0_stb = 0;
    step("wd_drop");
    s0_cyc = 1; s0_stb = 1;
    step("wd_rereq");
    #2;
    chk("wd_regnt.gnt", 32'(arb_gnt), 32'd1);
    wbm_ack = 1; arb_to_clr = 1;
    #1;
    check_all("wd_clr");
    adv();
    wbm_ack = 0; arb_to_clr = 0;
    #2;
    chk("wd_cleared.to", 32'(arb_to), 32'd0);
    check_all("wd_cleared");
    adv();

    // Reset in the middle of a GNT1 burst
    s0_cyc = 0; s0_stb = 0; s1_cyc = 1; s1_stb = 1;
    step("rb_req");
    #2;
    chk("rb_gnt1.gnt", 32'(arb_gnt), 32'd2);
    rst = 1;
    #1;
    chk("rb_async.cyc", 32'(wbm_cyc), 32'd0);
    chk("rb_async.gnt", 32'(arb_gnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    s0_cyc = 1; s0_stb = 1;
    rst = 0;
    #2;
    chk("rb_idle.gnt", 32'(arb_gnt), 32'd0);
    adv();
    #2;
    chk("rb_first.gnt", 32'(arb_gnt), 32'd1);
    check_all("rb_first");
    adv();

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) s0_cyc = ~s0_cyc;
      if ($urandom_range(7) == 0) s1_cyc = ~s1_cyc;
      s0_stb  = s0_cyc & ($urandom_range(15) != 0);
      s1_stb  = s1_cyc & ($urandom_range(15) != 0);
      s0_we   = 1'($urandom_range(1));
      s1_we   = 1'($urandom_range(1));
      s0_sel  = 4'($urandom);
      s1_sel  = 4'($urandom);
      s0_adr  = $urandom;
      s1_adr  = $urandom;
      wbm_ack = ($urandom_range(11) == 0);
      wbm_err = ($urandom_range(39) == 0);
      wbm_rty = ($urandom_range(39) == 0);
      arb_to_clr  = ($urandom_range(29) == 0);
      wbm_dat_o   = $urandom;
      wbm_dat64_o = $urandom;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
